// File: rtl/pattern_pkg.sv
// Shared definitions for the 16-bit test-pattern source and checker: modes, PRBS-15 taps,
// checker state encoding and the next-word predictor.
package pattern_pkg;

  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;

  localparam int PRBS_TAP_LO = 13;
  localparam int PRBS_TAP_HI = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_ACQ    = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Reserved modes return the word unchanged; the checker never predicts in them.
  function automatic logic [15:0] next_word(input logic [1:0] mode, input logic [15:0] v);
    logic [15:0] nxt;
    nxt = v;
    if (mode == MODE_CNT) begin
      nxt = v + 16'd1;
    end else if (mode == MODE_PRBS) begin
      nxt = {1'b0, v[13:0], v[PRBS_TAP_LO] ^ v[PRBS_TAP_HI]};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pattern_checker_16b_if.sv
// Pattern-checker bus: stimulus from the receive path (master) and status back from the checker (slave).
interface pattern_checker_16b_if #(
  parameter int W     = 16,
  parameter int CNT_W = 32
);
  logic             en;
  logic [1:0]       mode;
  logic [W-1:0]     din;
  logic             din_vld;
  logic             lock;
  logic             err;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_err_cnt;

  modport master (
    output en, mode, din, din_vld,
    input  lock, err, word_cnt, err_cnt, bit_err_cnt
  );

  modport slave (
    input  en, mode, din, din_vld,
    output lock, err, word_cnt, err_cnt, bit_err_cnt
  );
endinterface

// File: rtl/pattern_checker_16b_popcount.sv
// Combinational 16-bit population count, 5-bit result; no latency, no flow control.
module popcount_16 (
  input  logic [15:0] d,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(d[i]);
    end
  end

endmodule

// File: rtl/pattern_checker_16b.sv
// Self-synchronising counter / PRBS-15 checker; lock and err are registered one cycle after the
// causing word, and all state holds on cycles without din_vld (no backpressure is exerted).
module pattern_checker_16b
  import pattern_pkg::*;
#(
  parameter int W        = 16,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 CLK,
  input  logic                 CLEAR,
  pattern_checker_16b_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);
  localparam int SUM_W  = ((CNT_W > 5) ? CNT_W : 5) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX_EXT = SUM_W'({CNT_W{1'b1}});

  state_t             state_q, state_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [W-1:0]       ref_q, ref_nxt;
  logic [W-1:0]       exp_q, exp_nxt;
  logic [GOOD_W-1:0]  good_q, good_nxt;
  logic [BAD_W-1:0]   bad_q, bad_nxt;
  logic               lock_q;
  logic               err_q, err_nxt;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_nxt;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_nxt;
  logic [CNT_W-1:0]   bit_err_cnt_q, bit_err_cnt_nxt;

  logic [W-1:0]       pred_ref;
  logic [W-1:0]       pred_exp;
  logic [W-1:0]       diff;
  logic [4:0]         bit_errs;
  logic [SUM_W-1:0]   bit_sum;
  logic               cfg_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign pred_ref = next_word(mode_q, ref_q);
  assign pred_exp = next_word(mode_q, exp_q);
  assign diff     = bus.din ^ pred_exp;
  assign bit_sum  = SUM_W'(bit_err_cnt_q) + SUM_W'(bit_errs);
  assign cfg_ok   = bus.en && (bus.mode == mode_q);

  popcount_16 u_popcount (
    .d   (diff),
    .cnt (bit_errs)
  );

  always_comb begin
    state_nxt       = state_q;
    mode_nxt        = mode_q;
    ref_nxt         = ref_q;
    exp_nxt         = exp_q;
    good_nxt        = good_q;
    bad_nxt         = bad_q;
    err_nxt         = 1'b0;
    word_cnt_nxt    = word_cnt_q;
    err_cnt_nxt     = err_cnt_q;
    bit_err_cnt_nxt = bit_err_cnt_q;

    if (state_q == ST_IDLE) begin
      if (bus.en && (bus.mode < 2'd2)) begin
        mode_nxt  = bus.mode;
        state_nxt = ST_SEED;
      end
    end else if (!cfg_ok) begin
      state_nxt = ST_IDLE;
    end else if (bus.din_vld) begin
      unique case (state_q)
        ST_SEED: begin
          // An all-zero PRBS register is the lock-up state, so it cannot seed the predictor.
          if (!((mode_q == MODE_PRBS) && (bus.din == '0))) begin
            ref_nxt   = bus.din;
            good_nxt  = '0;
            state_nxt = ST_ACQ;
          end
        end
        ST_ACQ: begin
          ref_nxt = bus.din;
          if (bus.din == pred_ref) begin
            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
              good_nxt  = '0;
              bad_nxt   = '0;
              exp_nxt   = bus.din;
              state_nxt = ST_LOCKED;
            end else begin
              good_nxt = good_q + GOOD_W'(1);
            end
          end else begin
            good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel on the prediction so one corrupt word does not derail the following ones.
          exp_nxt      = pred_exp;
          word_cnt_nxt = sat_inc(word_cnt_q);
          if (diff != '0) begin
            err_nxt         = 1'b1;
            err_cnt_nxt     = sat_inc(err_cnt_q);
            bit_err_cnt_nxt = (bit_sum > CNT_MAX_EXT) ? '1 : bit_sum[CNT_W-1:0];
            if (bad_q == BAD_W'(LOSS_CNT - 1)) begin
              bad_nxt   = '0;
              state_nxt = ST_SEED;
            end else begin
              bad_nxt = bad_q + BAD_W'(1);
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_CNT;
      ref_q         <= '0;
      exp_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      lock_q        <= 1'b0;
      err_q         <= 1'b0;
      word_cnt_q    <= '0;
      err_cnt_q     <= '0;
      bit_err_cnt_q <= '0;
    end else begin
      state_q       <= state_nxt;
      mode_q        <= mode_nxt;
      ref_q         <= ref_nxt;
      exp_q         <= exp_nxt;
      good_q        <= good_nxt;
      bad_q         <= bad_nxt;
      lock_q        <= (state_nxt == ST_LOCKED);
      err_q         <= err_nxt;
      word_cnt_q    <= word_cnt_nxt;
      err_cnt_q     <= err_cnt_nxt;
      bit_err_cnt_q <= bit_err_cnt_nxt;
    end
  end

  assign bus.lock        = lock_q;
  assign bus.err         = err_q;
  assign bus.word_cnt    = word_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.bit_err_cnt = bit_err_cnt_q;

endmodule
